// File: rtl/mp_seg_pkg.sv
// Shared 7-segment definitions for the multiplexed display driver and its decoder.
// Keeping both tables here means the encode and decode sides cannot drift apart.
package mp_seg_pkg;

    localparam int SEG_W = 7;
    localparam int DIGITS = 4;

    // Bit order of DISP: {a,b,c,d,e,f,g}, a segment is lit when its bit is 0.
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        AN_IDLE,
        AN_ONE,
        AN_MULTI
    } an_class_t;

    typedef struct packed {
        logic [3:0] nibble;
        logic       legal;
        logic       blank;
    } seg_dec_t;

    // Anodes are active-low; count how many are driven.
    function automatic an_class_t classify_an(input logic [DIGITS-1:0] an);
        int lows;
        lows = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an[i]) lows++;
        end
        if (lows == 0) return AN_IDLE;
        if (lows == 1) return AN_ONE;
        return AN_MULTI;
    endfunction

    // Position of the lowest active anode; meaningful only for the AN_ONE class.
    function automatic logic [1:0] an_index(input logic [DIGITS-1:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern decoder: DISP -> {nibble, legal, blank}.
// Blank decodes as a legal pattern with nibble 0.
module seg7_decode
    import mp_seg_pkg::*;
(
    input  logic [SEG_W-1:0] disp,
    output seg_dec_t         dec
);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        dec = '{nibble: 4'h0, legal: 1'b1, blank: 1'b0};
        unique case (disp)
            SEG_0:     dec.nibble = 4'h0;
            SEG_1:     dec.nibble = 4'h1;
            SEG_2:     dec.nibble = 4'h2;
            SEG_3:     dec.nibble = 4'h3;
            SEG_4:     dec.nibble = 4'h4;
            SEG_5:     dec.nibble = 4'h5;
            SEG_6:     dec.nibble = 4'h6;
            SEG_7:     dec.nibble = 4'h7;
            SEG_8:     dec.nibble = 4'h8;
            SEG_9:     dec.nibble = 4'h9;
            SEG_A:     dec.nibble = 4'hA;
            SEG_B:     dec.nibble = 4'hB;
            SEG_C:     dec.nibble = 4'hC;
            SEG_D:     dec.nibble = 4'hD;
            SEG_E:     dec.nibble = 4'hE;
            SEG_F:     dec.nibble = 4'hF;
            SEG_BLANK: dec.blank  = 1'b1;
            default:   dec.legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mp_display_decoder.sv
// Receive side of the multiplexed 4-digit display: recovers each scanned digit
// and publishes a coherent 16-bit value once every anode has been seen.
module mp_display_decoder
    import mp_seg_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SEG_W-1:0]  disp,
    input  logic [DIGITS-1:0] an,
    output logic [15:0]       value,
    output logic [DIGITS-1:0] blank,
    output logic              decimal,
    output logic              frame,
    output logic              segerr,
    output logic              anerr,
    output logic              stale
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SETTLE - 1);
    localparam logic [TMO_W-1:0] TMO_TOP = TMO_W'(TIMEOUT);

    logic [SEG_W-1:0]      disp_q, disp_p;
    logic [DIGITS-1:0]     an_q, an_p;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [TMO_W-1:0]      tcnt, tcnt_nxt;
    logic [DIGITS-1:0]     seen, seen_nxt;
    logic [DIGITS-1:0][3:0] shadow;
    logic [DIGITS-1:0]     blank_s;

    logic       sample_diff;
    logic       act;
    logic       do_cap;
    logic       seg_bad;
    logic       an_bad;
    logic       frame_now;
    logic       all_dec;
    an_class_t  an_cls;
    logic [1:0] idx;
    seg_dec_t   dec;

    seg7_decode u_dec (
        .disp (disp_q),
        .dec  (dec)
    );

    // Stability: act fires once, on the edge where the dwell counter first reaches SETTLE-1.
    always_comb begin
        sample_diff = (disp_q != disp_p) || (an_q != an_p);
        cnt_nxt     = cnt;
        if (sample_diff) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_TOP) begin
            cnt_nxt = cnt + 1'b1;
        end
        act = (cnt_nxt == CNT_TOP) && (sample_diff || (cnt != CNT_TOP));
    end

    always_comb begin
        an_cls    = classify_an(an_q);
        idx       = an_index(an_q);
        do_cap    = act && (an_cls == AN_ONE) && dec.legal;
        seg_bad   = act && (an_cls == AN_ONE) && !dec.legal;
        an_bad    = act && (an_cls == AN_MULTI);
        frame_now = (seen == '1);

        // A capture on the frame edge starts the next frame's mask.
        seen_nxt = frame_now ? '0 : seen;
        if (do_cap) seen_nxt[idx] = 1'b1;

        tcnt_nxt = tcnt;
        if (do_cap) begin
            tcnt_nxt = '0;
        end else if (tcnt != TMO_TOP) begin
            tcnt_nxt = tcnt + 1'b1;
        end

        all_dec = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!blank_s[i] && (shadow[i] > 4'd9)) all_dec = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Input copies reset to idle/blank so no phantom dwell follows reset.
            disp_q  <= SEG_BLANK;
            disp_p  <= SEG_BLANK;
            an_q    <= '1;
            an_p    <= '1;
            cnt     <= '0;
            tcnt    <= '0;
            seen    <= '0;
            // NOTE: shadow digits are storage, but are cleared here so a post-reset frame never exposes stale data.
            shadow  <= '0;
            blank_s <= '0;
            value   <= '0;
            blank   <= '0;
            decimal <= 1'b0;
            frame   <= 1'b0;
            segerr  <= 1'b0;
            anerr   <= 1'b0;
            stale   <= 1'b0;
        end else begin
            disp_q <= disp;
            an_q   <= an;
            disp_p <= disp_q;
            an_p   <= an_q;
            cnt    <= cnt_nxt;
            tcnt   <= tcnt_nxt;
            seen   <= seen_nxt;
            frame  <= frame_now;
            segerr <= seg_bad;
            anerr  <= an_bad;

            if (do_cap) begin
                shadow[idx]  <= dec.nibble;
                blank_s[idx] <= dec.blank;
            end

            if (frame_now) begin
                value   <= shadow;
                blank   <= blank_s;
                decimal <= all_dec;
                stale   <= 1'b0;
            end else if (tcnt_nxt == TMO_TOP) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mp_display_decoder.sv
// Self-checking bench for mp_display_decoder: frame results are scoreboarded,
// error pulses and STALE are checked per scenario.
module tb_mp_display_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  disp;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        decimal;
    logic        frame;
    logic        segerr;
    logic        anerr;
    logic        stale;

    mp_display_decoder #(.SETTLE(2), .TIMEOUT(1024)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .disp    (disp),
        .an      (an),
        .value   (value),
        .blank   (blank),
        .decimal (decimal),
        .frame   (frame),
        .segerr  (segerr),
        .anerr   (anerr),
        .stale   (stale)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  blank;
        logic        decimal;
    } frame_t;

    frame_t exp_q[$];
    int checks     = 0;
    int failures   = 0;
    int frame_cnt  = 0;
    int anerr_cnt  = 0;
    int segerr_cnt = 0;
    bit mon_en     = 1'b0;

    localparam int BLANK_D = 16;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            15: return 7'b0111000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Scoreboard consumer: every FRAME pulse must match the oldest expected frame.
    always @(negedge clk) begin
        frame_t e;
        if (mon_en) begin
            if (frame) begin
                frame_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL frame_unexpected got value=%h blank=%b decimal=%b", value, blank, decimal);
                end else begin
                    e = exp_q.pop_front();
                    if ({value, blank, decimal} !== e) begin
                        failures++;
                        $display("FAIL frame_data got value=%h blank=%b decimal=%b expected value=%h blank=%b decimal=%b",
                                 value, blank, decimal, e.value, e.blank, e.decimal);
                    end
                end
            end
            if (anerr) anerr_cnt++;
            if (segerr) segerr_cnt++;
            if (anerr && segerr) begin
                checks++;
                failures++;
                $display("FAIL err_exclusive got anerr=1 segerr=1 expected at most one");
            end
        end
    end

    // All drive tasks start and end on a falling edge.
    task automatic hold(input logic [3:0] a, input logic [6:0] d, input int n);
        an   = a;
        disp = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(4'b1111, 7'b1111111, n);
    endtask

    task automatic push_frame(input int d0, input int d1, input int d2, input int d3);
        frame_t e;
        int ds[4];
        ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
        e.decimal = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e.blank[i]         = (ds[i] == BLANK_D);
            e.value[4*i +: 4]  = (ds[i] == BLANK_D) ? 4'h0 : 4'(ds[i]);
            if (ds[i] != BLANK_D && ds[i] > 9) e.decimal = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Full scan, 4 cycles per digit, starting at anode 'first' and wrapping.
    task automatic scan_frame(input int d0, input int d1, input int d2, input int d3, input int first);
        int ds[4];
        ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
        push_frame(d0, d1, d2, d3);
        for (int k = 0; k < 4; k++) begin
            int n;
            n = (first + k) % 4;
            hold(~(4'b0001 << n), enc(ds[n]), 4);
        end
        idle(6);
    endtask

    task automatic check_counts(input string name, input int df, input int da, input int ds,
                                input int f0, input int a0, input int s0);
        checks++;
        if ((frame_cnt - f0) !== df || (anerr_cnt - a0) !== da || (segerr_cnt - s0) !== ds) begin
            failures++;
            $display("FAIL %s got frame=%0d anerr=%0d segerr=%0d expected frame=%0d anerr=%0d segerr=%0d",
                     name, frame_cnt - f0, anerr_cnt - a0, segerr_cnt - s0, df, da, ds);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({value, blank, decimal, frame, segerr, anerr, stale} !== 26'd0) begin
            failures++;
            $display("FAIL %s got value=%h blank=%b decimal=%b frame=%b segerr=%b anerr=%b stale=%b expected all 0",
                     name, value, blank, decimal, frame, segerr, anerr, stale);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        disp  = 7'($urandom);
        an    = 4'($urandom);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check_zero_outputs("reset_outputs");
        mon_en = 1'b1;
        idle(4);
    endtask

    task automatic test_scan;
        int f0 = frame_cnt, a0 = anerr_cnt, s0 = segerr_cnt;
        scan_frame(5, 2, 0, 1, 0);
        check_counts("scan_counts", 1, 0, 0, f0, a0, s0);
        checks++;
        if (value !== 16'h1025 || blank !== 4'b0000 || decimal !== 1'b1) begin
            failures++;
            $display("FAIL scan_hold got value=%h blank=%b decimal=%b expected value=1025 blank=0000 decimal=1",
                     value, blank, decimal);
        end
    endtask

    task automatic test_glitch;
        int f0 = frame_cnt, a0 = anerr_cnt, s0 = segerr_cnt;
        hold(4'b1110, enc(3), 4);
        hold(4'b1101, enc(4), 1);
        hold(4'b1011, enc(BLANK_D), 4);
        hold(4'b0111, enc(8), 4);
        idle(6);
        check_counts("glitch_no_frame", 0, 0, 0, f0, a0, s0);
        push_frame(3, 4, BLANK_D, 8);
        hold(4'b1101, enc(4), 4);
        idle(6);
        check_counts("glitch_frame", 1, 0, 0, f0, a0, s0);
    endtask

    task automatic test_errors;
        int f0 = frame_cnt, a0 = anerr_cnt, s0 = segerr_cnt;
        hold(4'b1100, enc(5), 4);
        idle(4);
        check_counts("anerr_once", 0, 1, 0, f0, a0, s0);
        hold(4'b1110, 7'b1111110, 4);
        idle(4);
        check_counts("segerr_once", 0, 1, 1, f0, a0, s0);
        checks++;
        if (value !== 16'h8043 || blank !== 4'b0100 || decimal !== 1'b1) begin
            failures++;
            $display("FAIL err_value_hold got value=%h blank=%b decimal=%b expected value=8043 blank=0100 decimal=1",
                     value, blank, decimal);
        end
    endtask

    task automatic test_timeout;
        int f0 = frame_cnt, a0 = anerr_cnt, s0 = segerr_cnt;
        hold(4'b1110, enc(7), 4);
        idle(1000);
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL stale_early got %b expected 0", stale);
        end
        idle(40);
        checks++;
        if (stale !== 1'b1) begin
            failures++;
            $display("FAIL stale_set got %b expected 1", stale);
        end
        scan_frame(10, 11, 12, 13, 0);
        check_counts("timeout_frame", 1, 0, 0, f0, a0, s0);
        checks++;
        if (stale !== 1'b0 || value !== 16'hDCBA || decimal !== 1'b0) begin
            failures++;
            $display("FAIL stale_clear got stale=%b value=%h decimal=%b expected stale=0 value=dcba decimal=0",
                     stale, value, decimal);
        end
    endtask

    task automatic test_reset_midframe;
        int f0, a0, s0;
        hold(4'b1110, enc(0), 4);
        hold(4'b1101, enc(1), 4);
        hold(4'b1011, enc(2), 4);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        check_zero_outputs("midframe_reset_outputs");
        f0 = frame_cnt; a0 = anerr_cnt; s0 = segerr_cnt;
        // Start on the one anode not captured before reset.
        scan_frame(9, 9, 9, 9, 3);
        check_counts("midframe_single_frame", 1, 0, 0, f0, a0, s0);
        checks++;
        if (value !== 16'h9999) begin
            failures++;
            $display("FAIL midframe_value got %h expected 9999", value);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        disp  = 7'h7F;
        an    = 4'hF;
        @(negedge clk);
        test_reset();
        test_scan();
        test_glitch();
        test_errors();
        test_timeout();
        test_reset_midframe();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL frames_missing got pending=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
